axi_stream_to_bt656: RTL and testbench
======================================

// Module: axi_stream_to_bt656
// PURPOSE
// - Transmit side of the BT.656 video path: takes YUV 4:2:2 pixels from an AXI4-Stream (VDMA MM2S
//   or the test-pattern generator) and emits a byte-serial 8-bit BT.656 stream.
// - Output includes EAV/SAV timing codes, horizontal blanking and vertical blanking lines.
// - Progressive only (F=0). Output timing is isochronous: the stream never stalls the video output.
// PARAMETERS
// - DW  16  AXI TDATA width; only 16 is legal. [15:8] = chroma (Cb on even px, Cr on odd px), [7:0] = Y.
// - CW  11  width of all geometry counters and config ports.
// PORTS
// - axi_clk_i      in   1   single clock; one BT.656 byte per cycle (27 MHz for SD).
// - axi_rstn_i     in   1   asynchronous, active-low reset.
// - s_tdata_i      in   DW  pixel data.
// - s_tvalid_i     in   1   pixel valid.
// - s_tuser_i      in   1   start of frame, on the first pixel of a frame.
// - s_tlast_i      in   1   end of line, on the last pixel of a line.
// - s_tready_o     out  1   pixel accepted.
// - en_i           in   1   transmit enable.
// - cfg_width_i    in   CW  active pixels per line; even, >=2.
// - cfg_height_i   in   CW  active lines per frame; >=1.
// - cfg_hblank_i   in   CW  blanking bytes between EAV and SAV; even, >=2.
// - cfg_vblank_i   in   CW  vertical blanking lines at frame start; >=1.
// - clr_i          in   1   one-cycle pulse; clears the sticky flags.
// - bt656_data_o   out  8   BT.656 byte, registered.
// - underflow_o    out  1   sticky: a pixel was due but s_tvalid_i was low.
// - sof_err_o      out  1   sticky: tuser missing or misplaced.
// - eol_err_o      out  1   sticky: tlast on the wrong pixel.
// BEHAVIOUR
// - Reset: bt656_data_o=8'h10, s_tready_o=0, flags=0, FSM=IDLE, all counters=0.
// - IDLE: output alternates 8'h80/8'h10; s_tready_o=0. While en_i=1, enters EAV on the next cycle,
//   with line=0 and the config ports latched. Config is also latched at each frame start.
// - Line sequence: EAV(FF 00 00 XY) -> HBLANK(80,10 repeated, cfg_hblank bytes) -> SAV(FF 00 00 XY)
//   -> ACTIVE(2*cfg_width bytes) -> next line's EAV.
// - XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}.
//   - Lines 0..cfg_vblank-1 have V=1; lines cfg_vblank..cfg_vblank+cfg_height-1 have V=0.
//   - Resulting codes: blank EAV B6, blank SAV AB, active EAV 9D, active SAV 80.
// - Frame end: after the last line's ACTIVE, line wraps to 0.
//   - If en_i=0, go to IDLE; en_i is only honoured at frame boundaries.
// - ACTIVE on a V=0 line, per pixel:
//   - Even byte: output chroma. s_tready_o=1 on the cycle that chroma byte is loaded into the
//     output register.
//   - Odd byte: output the captured Y.
//   - Latency: handshake cycle n -> chroma on data_o at n+1, Y at n+2.
// - Underflow: s_tready_o=1 with s_tvalid_i=0 -> emit 80 then 10 for that pixel, set underflow_o,
//   keep timing; the pixel is not consumed later.
// - ACTIVE on a V=1 line: emit 80/10 pairs.
//   - s_tready_o=1 every even byte only if the head beat has s_tuser_i=0 (flush).
//   - Each flushed beat sets sof_err_o.
//   - A head beat with s_tuser_i=1 is held for the first active pixel.
// - Checks on consumed beats (set the flag only, no change to timing):
//   - First pixel of the frame has s_tuser_i=0, or s_tuser_i=1 on any other pixel -> sof_err_o.
//   - s_tlast_i != (pixel==cfg_width-1) -> eol_err_o.
// - Simultaneous clr_i and a flag event: the set wins.
// - Reset mid-line: immediate return to reset values; the next frame starts from IDLE with EAV.
// - Arithmetic: byte counter is CW+1 bits to hold 2*cfg_width-1; compares are unsigned.
//   - Counters wrap only through the FSM, never by overflow.
// STRUCTURE
// - bt656_pkg:
//   - constants BT656_BLANK_Y=8'h10, BT656_BLANK_C=8'h80, preamble FF/00;
//   - function bt656_xy(f,v,h) returning the protected XY byte;
//   - typedef enum tx_state_t {IDLE,EAV,HBLANK,SAV,ACTIVE}.
// - No sub-modules: one FSM, byte/line counters, a Y hold register, the output register.
// TESTING
// - Reset with en_i=0 -> data_o=10, tready=0, flags=0; it then alternates 80/10.
// - Frame width=4, height=2, hblank=4, vblank=1, 8 valid pixels (tuser first, tlast px3/px7):
//   - Line0: FF 00 00 B6 80 10 80 10 FF 00 00 AB 80 10 80 10 80 10 80 10.
//   - Line1: ... 9D ... 80, then C0 Y0 C1 Y1 ... exactly; no flags set.
// - Same frame, tvalid dropped for px2 -> bytes 80 10 at px2, px3 data follows, underflow_o=1.
// - Two stray beats (tuser=0) queued before the tuser beat -> both flushed during line0,
//   sof_err_o=1, line1 carries the tuser pixel as px0.
// - tlast on px2 -> eol_err_o=1 and the byte sequence is unchanged; clr_i -> eol_err_o=0 next cycle.
// - en_i dropped mid line1 -> line1 completes, then IDLE; reset asserted mid-ACTIVE -> data_o=10
//   asynchronously.

Source files
------------

// File: rtl/bt656_pkg.sv
// rtl/bt656_pkg.sv - BT.656 byte constants, protected XY helper and transmitter state type.
package bt656_pkg;

  localparam logic [7:0] BT656_BLANK_Y = 8'h10;
  localparam logic [7:0] BT656_BLANK_C = 8'h80;
  localparam logic [7:0] BT656_PRE_FF  = 8'hFF;
  localparam logic [7:0] BT656_PRE_00  = 8'h00;

  typedef enum logic [2:0] {IDLE, EAV, HBLANK, SAV, ACTIVE} tx_state_t;

  function automatic logic [7:0] bt656_xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/axi_stream_to_bt656.sv
// rtl/axi_stream_to_bt656.sv - AXI4-Stream YUV 4:2:2 to isochronous 8-bit BT.656 transmitter.
// State and counters describe the byte being loaded into the output register this cycle.
module axi_stream_to_bt656
  import bt656_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 11
) (
  input  logic          axi_clk_i,
  input  logic          axi_rstn_i,
  input  logic [DW-1:0] s_tdata_i,
  input  logic          s_tvalid_i,
  input  logic          s_tuser_i,
  input  logic          s_tlast_i,
  output logic          s_tready_o,
  input  logic          en_i,
  input  logic [CW-1:0] cfg_width_i,
  input  logic [CW-1:0] cfg_height_i,
  input  logic [CW-1:0] cfg_hblank_i,
  input  logic [CW-1:0] cfg_vblank_i,
  input  logic          clr_i,
  output logic [7:0]    bt656_data_o,
  output logic          underflow_o,
  output logic          sof_err_o,
  output logic          eol_err_o
);

  localparam logic [CW:0] ONE   = (CW+1)'(1);
  localparam logic [CW:0] THREE = (CW+1)'(3);

  tx_state_t     state_q;
  logic [CW:0]   cnt_q, line_q;
  logic [CW-1:0] width_q, height_q, hblank_q, vblank_q;
  logic [7:0]    data_q, y_q;
  logic          pix_ok_q, unf_q, sof_q, eol_q;

  logic [CW:0] vb_ext, act_last, hb_last, frame_last;
  logic        v_blank, even, act_v, act_b, hs, sof_exp, pix_last;
  logic        unf_ev, sof_ev, eol_ev;
  logic [7:0]  byte_d;

  always_comb begin
    vb_ext     = {1'b0, vblank_q};
    act_last   = {width_q, 1'b0} - ONE;
    hb_last    = {1'b0, hblank_q} - ONE;
    frame_last = vb_ext + {1'b0, height_q} - ONE;
    v_blank    = line_q < vb_ext;
    even       = ~cnt_q[0];
    act_v      = (state_q == ACTIVE) && !v_blank;
    act_b      = (state_q == ACTIVE) && v_blank;
    // Blank lines only drain beats that cannot be a frame start.
    s_tready_o = (act_v && even) || (act_b && even && s_tvalid_i && !s_tuser_i);
    hs         = s_tready_o && s_tvalid_i;
    sof_exp    = (line_q == vb_ext) && (cnt_q == '0);
    pix_last   = cnt_q == (act_last - ONE);
    unf_ev     = act_v && even && !s_tvalid_i;
    sof_ev     = hs && (act_b || (s_tuser_i != sof_exp));
    eol_ev     = hs && act_v && (s_tlast_i != pix_last);
  end

  always_comb begin
    byte_d = BT656_BLANK_Y;
    unique case (state_q)
      IDLE, HBLANK: byte_d = cnt_q[0] ? BT656_BLANK_Y : BT656_BLANK_C;
      EAV, SAV: begin
        unique case (cnt_q[1:0])
          2'd0:    byte_d = BT656_PRE_FF;
          2'd3:    byte_d = bt656_xy(1'b0, v_blank, state_q == EAV);
          default: byte_d = BT656_PRE_00;
        endcase
      end
      ACTIVE: begin
        if (v_blank)        byte_d = even ? BT656_BLANK_C : BT656_BLANK_Y;
        else if (even)      byte_d = s_tvalid_i ? s_tdata_i[15:8] : BT656_BLANK_C;
        else                byte_d = pix_ok_q ? y_q : BT656_BLANK_Y;
      end
      default: byte_d = BT656_BLANK_Y;
    endcase
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      hblank_q <= '0;
      vblank_q <= '0;
      data_q   <= BT656_BLANK_Y;
      y_q      <= '0;
      pix_ok_q <= 1'b0;
      unf_q    <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      data_q <= byte_d;
      unf_q  <= (unf_q & ~clr_i) | unf_ev;
      sof_q  <= (sof_q & ~clr_i) | sof_ev;
      eol_q  <= (eol_q & ~clr_i) | eol_ev;
      if (act_v && even) begin
        pix_ok_q <= s_tvalid_i;
        if (s_tvalid_i) y_q <= s_tdata_i[7:0];
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= {cnt_q[CW:1], ~cnt_q[0]};
          if (en_i) begin
            state_q  <= EAV;
            cnt_q    <= '0;
            line_q   <= '0;
            width_q  <= cfg_width_i;
            height_q <= cfg_height_i;
            hblank_q <= cfg_hblank_i;
            vblank_q <= cfg_vblank_i;
          end
        end
        EAV, SAV: begin
          if (cnt_q == THREE) begin
            state_q <= (state_q == EAV) ? HBLANK : ACTIVE;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + ONE;
        end
        HBLANK: begin
          if (cnt_q == hb_last) begin
            state_q <= SAV;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + ONE;
        end
        ACTIVE: begin
          if (cnt_q == act_last) begin
            cnt_q <= '0;
            if (line_q == frame_last) begin
              line_q <= '0;
              if (en_i) begin
                state_q  <= EAV;
                width_q  <= cfg_width_i;
                height_q <= cfg_height_i;
                hblank_q <= cfg_hblank_i;
                vblank_q <= cfg_vblank_i;
              end else state_q <= IDLE;
            end else begin
              line_q  <= line_q + ONE;
              state_q <= EAV;
            end
          end else cnt_q <= cnt_q + ONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bt656_data_o = data_q;
  assign underflow_o  = unf_q;
  assign sof_err_o    = sof_q;
  assign eol_err_o    = eol_q;

endmodule

// File: tb/tb_axi_stream_to_bt656.sv
// tb/tb_axi_stream_to_bt656.sv - self-checking bench with a frame-position reference model.
module tb_axi_stream_to_bt656;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, s_tvalid, s_tuser, s_tlast, s_tready, en, clr;
  logic [15:0] s_tdata;
  logic [10:0] cfg_w, cfg_h, cfg_hb, cfg_vb;
  logic [7:0]  data;
  logic        unf, sof, eol;

  axi_stream_to_bt656 dut (
    .axi_clk_i(clk), .axi_rstn_i(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
    .s_tready_o(s_tready), .en_i(en),
    .cfg_width_i(cfg_w), .cfg_height_i(cfg_h), .cfg_hblank_i(cfg_hb), .cfg_vblank_i(cfg_vb),
    .clr_i(clr), .bt656_data_o(data),
    .underflow_o(unf), .sof_err_o(sof), .eol_err_o(eol)
  );

  typedef struct packed {logic [7:0] c; logic [7:0] y; logic user; logic last;} beat_t;
  beat_t q[$];

  int n_chk = 0, n_err = 0;
  int W, H, HB, VB, drop_pct, drop_line, drop_p, m_c, m_frame, pend;
  bit en_drv, clr_drv, m_run, m_idle_ph, m_pix_ok, ef_unf, ef_sof, ef_eol;
  logic [7:0] m_y, exp_data;
  logic [7:0] logb [0:255];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb);
    W = w; H = h; HB = hb; VB = vb;
    cfg_w = 11'(w); cfg_h = 11'(h); cfg_hb = 11'(hb); cfg_vb = 11'(vb);
  endtask

  task automatic model_init();
    rst_n = 1'b1;
    q.delete();
    en_drv = 0; clr_drv = 0; drop_line = -1; drop_p = -1;
    m_run = 0; m_idle_ph = 0; m_pix_ok = 0; m_c = 0; m_frame = 0; m_y = 8'h00;
    ef_unf = 0; ef_sof = 0; ef_eol = 0; exp_data = 8'h10; pend = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 0; clr = 0;
    s_tvalid = 0; s_tdata = '0; s_tuser = 0; s_tlast = 0;
    #1;
    chk("rst_data", data, 8'h10);
    chk("rst_tready", {7'b0, s_tready}, 8'h00);
    chk("rst_flags", {5'b0, unf, sof, eol}, 8'h00);
    @(negedge clk);
    model_init();
  endtask

  // One clock: check last cycle's outputs, drive inputs, predict this cycle's load.
  task automatic step();
    int L, FL, line, k, a, p;
    bit vb, act, even, drop, rdy, hs, e_unf, e_sof, e_eol;
    logic [7:0] b, xy;
    chk("data", data, exp_data);
    chk("flags", {5'b0, unf, sof, eol}, {5'b0, ef_unf, ef_sof, ef_eol});
    if (pend >= 0) logb[pend] = data;
    L = 8 + HB + 2 * W; FL = (VB + H) * L;
    line = 0; k = 0; a = 0; p = 0; vb = 0; act = 0; even = 0;
    if (m_run) begin
      line = m_c / L; k = m_c % L; vb = line < VB;
      if (k >= 8 + HB) begin act = 1; a = k - 8 - HB; p = a / 2; even = (a % 2) == 0; end
    end
    drop = (drop_pct > 0 && int'($urandom_range(99)) < drop_pct) ||
           (act && even && !vb && line == drop_line && p == drop_p);
    en = en_drv; clr = clr_drv;
    if (q.size() > 0 && !drop) begin
      s_tvalid = 1; s_tdata = {q[0].c, q[0].y}; s_tuser = q[0].user; s_tlast = q[0].last;
    end else begin
      s_tvalid = 0; s_tdata = '0; s_tuser = 0; s_tlast = 0;
    end
    #1;
    rdy = act && even && (!vb || (s_tvalid && !s_tuser));
    chk("tready", {7'b0, s_tready}, {7'b0, rdy});
    hs = rdy && s_tvalid;
    e_unf = 0; e_sof = 0; e_eol = 0;
    xy = vb ? ((k < 4) ? 8'hB6 : 8'hAB) : ((k < 4) ? 8'h9D : 8'h80);
    if (!m_run)                b = m_idle_ph ? 8'h10 : 8'h80;
    else if (k < 4)            b = (k == 0) ? 8'hFF : (k == 3) ? xy : 8'h00;
    else if (k < 4 + HB)       b = ((k - 4) % 2 == 0) ? 8'h80 : 8'h10;
    else if (k < 8 + HB)       b = (k == 4 + HB) ? 8'hFF : (k == 7 + HB) ? xy : 8'h00;
    else if (vb)               b = even ? 8'h80 : 8'h10;
    else if (even)             b = s_tvalid ? q[0].c : 8'h80;
    else                       b = m_pix_ok ? m_y : 8'h10;
    if (act && even && !vb) begin
      if (s_tvalid) begin
        m_y = q[0].y; m_pix_ok = 1;
        e_sof = q[0].user != (line == VB && p == 0);
        e_eol = q[0].last != (p == W - 1);
      end else begin
        m_pix_ok = 0; e_unf = 1;
      end
    end
    if (hs && vb) e_sof = 1;
    if (hs) void'(q.pop_front());
    ef_unf = (ef_unf && !clr_drv) || e_unf;
    ef_sof = (ef_sof && !clr_drv) || e_sof;
    ef_eol = (ef_eol && !clr_drv) || e_eol;
    exp_data = b;
    pend = (m_run && m_frame == 0 && m_c < 256) ? m_c : -1;
    if (m_run) begin
      if (m_c == FL - 1) begin
        if (en_drv) begin m_c = 0; m_frame++; end
        else begin m_run = 0; m_idle_ph = 0; end
      end else m_c++;
    end else begin
      m_idle_ph = !m_idle_ph;
      if (en_drv) begin m_run = 1; m_c = 0; m_frame = 0; end
    end
    @(negedge clk);
  endtask

  task automatic push_frame(input int n, input int bad_px);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.c = 8'(8'hA0 + i); bt.y = 8'(8'h20 + i);
      bt.user = (i == 0); bt.last = (i % W) == W - 1;
      if (bad_px >= 0 && i == bad_px) bt.last = 1;
      if (bad_px >= 0 && i == bad_px + 1) bt.last = 0;
      q.push_back(bt);
    end
  endtask

  // Start from IDLE, drop en in the middle of line 1 of the 60-cycle reference frame.
  task automatic run_ref_frame();
    en_drv = 1; step();
    repeat (30) step();
    en_drv = 0;
    repeat (34) step();
  endtask

  logic [7:0] l0 [20];
  logic [7:0] l1 [20];
  logic [7:0] l2 [20];

  initial begin
    beat_t bt;
    int fl;
    l0 = '{8'hFF,8'h00,8'h00,8'hB6,8'h80,8'h10,8'h80,8'h10,8'hFF,8'h00,8'h00,8'hAB,
           8'h80,8'h10,8'h80,8'h10,8'h80,8'h10,8'h80,8'h10};
    l1 = '{8'hFF,8'h00,8'h00,8'h9D,8'h80,8'h10,8'h80,8'h10,8'hFF,8'h00,8'h00,8'h80,
           8'hA0,8'h20,8'hA1,8'h21,8'hA2,8'h22,8'hA3,8'h23};
    l2 = '{8'hFF,8'h00,8'h00,8'h9D,8'h80,8'h10,8'h80,8'h10,8'hFF,8'h00,8'h00,8'h80,
           8'hA4,8'h24,8'hA5,8'h25,8'hA6,8'h26,8'hA7,8'h27};
    rst_n = 0; en = 0; clr = 0; s_tvalid = 0; s_tdata = '0; s_tuser = 0; s_tlast = 0;
    drop_pct = 0;
    set_cfg(4, 2, 4, 1);
    @(negedge clk);
    do_reset();

    step(); chk("idle_first", data, 8'h80);
    step(); chk("idle_second", data, 8'h10);
    step();

    push_frame(8, -1);
    run_ref_frame();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("ref_line0_%0d", i), logb[i], l0[i]);
      chk($sformatf("ref_line1_%0d", i), logb[20 + i], l1[i]);
      chk($sformatf("ref_line2_%0d", i), logb[40 + i], l2[i]);
    end
    chk("ref_flags", {5'b0, unf, sof, eol}, 8'h00);

    do_reset();
    push_frame(8, -1);
    drop_line = 1; drop_p = 2;
    run_ref_frame();
    chk("unf_px2_c", logb[36], 8'h80);
    chk("unf_px2_y", logb[37], 8'h10);
    chk("unf_px3_c", logb[38], 8'hA2);
    chk("unf_px3_y", logb[39], 8'h22);
    chk("unf_flag", {7'b0, unf}, 8'h01);

    do_reset();
    bt.c = 8'h55; bt.y = 8'h66; bt.user = 0; bt.last = 0;
    q.push_back(bt); q.push_back(bt);
    push_frame(8, -1);
    run_ref_frame();
    chk("stray_sof", {7'b0, sof}, 8'h01);
    chk("stray_px0_c", logb[32], 8'hA0);
    chk("stray_px0_y", logb[33], 8'h20);

    do_reset();
    push_frame(8, 2);
    run_ref_frame();
    for (int i = 0; i < 20; i++) chk($sformatf("eol_line1_%0d", i), logb[20 + i], l1[i]);
    chk("eol_set", {7'b0, eol}, 8'h01);
    clr_drv = 1; step(); clr_drv = 0;
    chk("eol_clr", {7'b0, eol}, 8'h00);
    step();

    do_reset();
    push_frame(8, -1);
    en_drv = 1; step();
    repeat (35) step();
    #2 rst_n = 0;
    #1 chk("async_rst_data", data, 8'h10);
    chk("async_rst_tready", {7'b0, s_tready}, 8'h00);
    @(negedge clk);
    model_init();
    step();
    push_frame(8, -1);
    run_ref_frame();
    for (int i = 0; i < 4; i++) chk($sformatf("after_rst_eav_%0d", i), logb[i], l0[i]);
    chk("after_rst_px0", logb[32], 8'hA0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      set_cfg(2 * $urandom_range(1, 4), $urandom_range(1, 3), 2 * $urandom_range(1, 3), $urandom_range(1, 2));
      drop_pct = 10;
      fl = (VB + H) * (8 + HB + 2 * W);
      for (int f = 0; f < 3; f++)
        for (int i = 0; i < W * H; i++) begin
          bt.c = 8'($urandom); bt.y = 8'($urandom); bt.user = (i == 0);
          bt.last = ((i % W) == W - 1) ^ ($urandom_range(19) == 0);
          q.push_back(bt);
        end
      en_drv = 1;
      for (int c = 0; c < 1 + 2 * fl + int'($urandom_range(fl - 1)); c++) begin
        clr_drv = $urandom_range(49) == 0;
        step();
      end
      en_drv = 0; clr_drv = 0;
      repeat (fl + 4) step();
      drop_pct = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
